// File: rtl/clock_source_pkg.sv
// Shared defaults and per-channel state record for clock_source_div.
// Optional phase alignment is built with CLKSRC_PHASE_SYNC_EN.
package clock_source_pkg;

   localparam int NCH_DEF  = 2;
   localparam int DIVW_DEF = 8;
   localparam int MAX_NCH  = 8;

   typedef struct packed {
      logic active;
      logic pend;
      logic inv_act;
      logic arm;
   } ch_state_t;

endpackage

// File: rtl/clock_source_div_ch.sv
// One divider channel: counter, shadow ratio, boundary-applied updates.
// CLKSRC_PHASE_SYNC_EN adds i_sync, which forces a period boundary.
module clock_source_div_ch
   import clock_source_pkg::*;
#(
   parameter int DIVW = DIVW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_en,
   input  logic            i_ld,
   input  logic [DIVW-1:0] i_val,
   input  logic            i_inv,
   input  logic            i_scan,
`ifdef CLKSRC_PHASE_SYNC_EN
   input  logic            i_sync,
`endif
   output logic            o_ce,
   output logic            o_divclk,
   output logic            o_active,
   output logic            o_pend
);

   logic [DIVW-1:0] r_cnt;
   logic [DIVW-1:0] r_dact;
   logic [DIVW-1:0] r_dshd;
   ch_state_t       r_st;
   logic            r_scan;
   logic            r_divclk;

   logic [DIVW-1:0] w_cnt_n;
   logic [DIVW-1:0] w_dact_n;
   logic [DIVW-1:0] w_dshd_n;
   ch_state_t       w_st_n;
   logic            w_wrap;
   logic            w_bnd;
   logic [DIVW:0]   w_half;
   logic            w_raw_n;

   assign w_wrap = r_st.active && (r_cnt == r_dact);

`ifdef CLKSRC_PHASE_SYNC_EN
   assign w_bnd = r_st.active && (w_wrap || i_sync);
`else
   assign w_bnd = w_wrap;
`endif

   always_comb begin
      w_cnt_n  = r_cnt;
      w_dact_n = r_dact;
      w_dshd_n = r_dshd;
      w_st_n   = r_st;
      if (!i_scan) begin
         if (i_ld) begin
            w_dshd_n    = i_val;
            w_st_n.pend = 1'b1;
         end
         if (!r_st.active) begin
            w_cnt_n        = '0;
            w_st_n.inv_act = i_inv;
            w_st_n.arm     = i_en;
            if (r_st.pend) begin
               w_dact_n = r_dshd;
               if (!i_ld) begin
                  w_st_n.pend = 1'b0;
               end
            end
            // enable sampled last cycle starts the first period now
            if (r_st.arm) begin
               w_st_n.active = 1'b1;
               w_st_n.arm    = 1'b0;
            end
         end else if (w_bnd) begin
            w_cnt_n        = '0;
            w_st_n.inv_act = i_inv;
            if (i_ld) begin
               w_dact_n    = i_val;
               w_st_n.pend = 1'b0;
            end else if (r_st.pend) begin
               w_dact_n    = r_dshd;
               w_st_n.pend = 1'b0;
            end
            if (!i_en) begin
               w_st_n.active = 1'b0;
            end
         end else begin
            w_cnt_n = r_cnt + DIVW'(1);
         end
      end
      w_half  = ({1'b0, w_dact_n} + {{DIVW{1'b0}}, 1'b1}) >> 1;
      w_raw_n = w_st_n.active && ({1'b0, w_cnt_n} < w_half);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_dact   <= '0;
         r_dshd   <= '0;
         r_st     <= '0;
         r_scan   <= 1'b0;
         r_divclk <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_n;
         r_dact   <= w_dact_n;
         r_dshd   <= w_dshd_n;
         r_st     <= w_st_n;
         r_scan   <= i_scan;
         r_divclk <= i_scan ? 1'b0 : (w_raw_n ^ w_st_n.inv_act);
      end
   end

   assign o_ce     = r_scan | w_wrap;
   assign o_divclk = r_divclk;
   assign o_active = r_st.active;
   assign o_pend   = r_st.pend;

endmodule

// File: rtl/clock_source_div.sv
// Multi-channel clock-enable / divided-clock generator.
// Define CLKSRC_PHASE_SYNC_EN to add the sync_pulse phase-alignment input.
module clock_source_div
   import clock_source_pkg::*;
#(
   parameter int NCH  = NCH_DEF,
   parameter int DIVW = DIVW_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCH-1:0]      ch_en,
   input  logic [NCH-1:0]      div_ld,
   input  logic [NCH*DIVW-1:0] div_val,
   input  logic [NCH-1:0]      inv,
   input  logic                scan_mode,
`ifdef CLKSRC_PHASE_SYNC_EN
   input  logic                sync_pulse,
`endif
   output logic [NCH-1:0]      ce,
   output logic [NCH-1:0]      divclk,
   output logic [NCH-1:0]      ch_active,
   output logic [NCH-1:0]      upd_pend
);

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      clock_source_div_ch #(
         .DIVW (DIVW)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .i_en     (ch_en[g]),
         .i_ld     (div_ld[g]),
         .i_val    (div_val[g*DIVW +: DIVW]),
         .i_inv    (inv[g]),
         .i_scan   (scan_mode),
`ifdef CLKSRC_PHASE_SYNC_EN
         .i_sync   (sync_pulse),
`endif
         .o_ce     (ce[g]),
         .o_divclk (divclk[g]),
         .o_active (ch_active[g]),
         .o_pend   (upd_pend[g])
      );
   end

endmodule

// File: tb/tb_clock_source_div.sv
// Directed self-checking bench for clock_source_div.
// Phase-sync scenario is built only with CLKSRC_PHASE_SYNC_EN.
module tb_clock_source_div;

   localparam int NCH  = 2;
   localparam int DIVW = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic [NCH-1:0]      ch_en;
   logic [NCH-1:0]      div_ld;
   logic [NCH*DIVW-1:0] div_val;
   logic [NCH-1:0]      inv;
   logic                scan_mode;
`ifdef CLKSRC_PHASE_SYNC_EN
   logic                sync_pulse;
`endif
   logic [NCH-1:0]      ce;
   logic [NCH-1:0]      divclk;
   logic [NCH-1:0]      ch_active;
   logic [NCH-1:0]      upd_pend;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   clock_source_div #(
      .NCH  (NCH),
      .DIVW (DIVW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ch_en      (ch_en),
      .div_ld     (div_ld),
      .div_val    (div_val),
      .inv        (inv),
      .scan_mode  (scan_mode),
`ifdef CLKSRC_PHASE_SYNC_EN
      .sync_pulse (sync_pulse),
`endif
      .ce         (ce),
      .divclk     (divclk),
      .ch_active  (ch_active),
      .upd_pend   (upd_pend)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load0(input logic [DIVW-1:0] d);
      div_val[DIVW-1:0] = d;
      div_ld[0] = 1'b1;
      step();
      div_ld[0] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ch_en = '0;
      div_ld = '0;
      div_val = '0;
      inv = '0;
      scan_mode = 1'b0;
`ifdef CLKSRC_PHASE_SYNC_EN
      sync_pulse = 1'b0;
`endif
      step();
      step();
      n_chk++;
      if (ce !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ce got %b want 00", ce);
      end
      n_chk++;
      if (divclk !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_divclk got %b want 00", divclk);
      end
      n_chk++;
      if (ch_active !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_active got %b want 00", ch_active);
      end
      n_chk++;
      if (upd_pend !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_pend got %b want 00", upd_pend);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      logic [1:0] exp_t [6];
      exp_t = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10};
      load0(8'd2);
      n_chk++;
      if (upd_pend !== 2'b01) begin
         n_fail++;
         $display("FAIL idle_pend_set got %b want 01", upd_pend);
      end
      step();
      n_chk++;
      if (upd_pend !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_pend_apply got %b want 00", upd_pend);
      end
      ch_en[0] = 1'b1;
      step();
      n_chk++;
      if (ch_active !== 2'b00) begin
         n_fail++;
         $display("FAIL en_edge_active got %b want 00", ch_active);
      end
      step();
      n_chk++;
      if (ch_active !== 2'b01) begin
         n_fail++;
         $display("FAIL en_next_active got %b want 01", ch_active);
      end
      for (int i = 0; i < 6; i++) begin
         n_chk++;
         if ({ce[0], divclk[0]} !== exp_t[i]) begin
            n_fail++;
            $display("FAIL n3_cyc%0d ce_dv got %b want %b",
                     i, {ce[0], divclk[0]}, exp_t[i]);
         end
         if (i < 5) step();
      end
   endtask

   task automatic test_ratio1();
      logic [1:0] exp_t [4];
      exp_t = '{2'b01, 2'b10, 2'b01, 2'b10};
      load0(8'd0);
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if ({ce[0], divclk[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL n1_cyc%0d ce_dv got %b want 10",
                     i, {ce[0], divclk[0]});
         end
         if (i < 2) step();
      end
      load0(8'd1);
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if ({ce[0], divclk[0]} !== exp_t[i]) begin
            n_fail++;
            $display("FAIL n2_cyc%0d ce_dv got %b want %b",
                     i, {ce[0], divclk[0]}, exp_t[i]);
         end
         if (i < 3) step();
      end
   endtask

   task automatic test_update();
      load0(8'd4);
      n_chk++;
      if (upd_pend[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL upd_bnd_pend got %b want 0", upd_pend[0]);
      end
      step();
      step();
      load0(8'd1);
      n_chk++;
      if (upd_pend[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL upd_mid_pend got %b want 1", upd_pend[0]);
      end
      step();
      n_chk++;
      if ({ce[0], upd_pend[0]} !== 2'b11) begin
         n_fail++;
         $display("FAIL upd_last ce_pend got %b want 11",
                  {ce[0], upd_pend[0]});
      end
      step();
      n_chk++;
      if ({ce[0], upd_pend[0]} !== 2'b00) begin
         n_fail++;
         $display("FAIL upd_applied ce_pend got %b want 00",
                  {ce[0], upd_pend[0]});
      end
      step();
      n_chk++;
      if (ce[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL upd_n2_ce got %b want 1", ce[0]);
      end
      load0(8'd4);
      n_chk++;
      if (upd_pend[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bnd_ld_pend got %b want 0", upd_pend[0]);
      end
      for (int i = 0; i < 4; i++) step();
      n_chk++;
      if (ce[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL n5_end_ce got %b want 1", ce[0]);
      end
      load0(8'd1);
      n_chk++;
      if ({ce[0], divclk[0]} !== 2'b01) begin
         n_fail++;
         $display("FAIL bnd_ld_start ce_dv got %b want 01",
                  {ce[0], divclk[0]});
      end
      step();
      n_chk++;
      if (ce[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL bnd_ld_n2_ce got %b want 1", ce[0]);
      end
   endtask

   task automatic test_disable();
      load0(8'd5);
      step();
      ch_en[0] = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_chk++;
      if ({ch_active[0], ce[0]} !== 2'b11) begin
         n_fail++;
         $display("FAIL dis_last act_ce got %b want 11",
                  {ch_active[0], ce[0]});
      end
      step();
      n_chk++;
      if ({ch_active[0], ce[0], divclk[0]} !== 3'b000) begin
         n_fail++;
         $display("FAIL dis_idle act_ce_dv got %b want 000",
                  {ch_active[0], ce[0], divclk[0]});
      end
      ch_en[0] = 1'b1;
      step();
      step();
      n_chk++;
      if (ch_active[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL reen_active got %b want 1", ch_active[0]);
      end
      step();
      ch_en[0] = 1'b0;
      step();
      ch_en[0] = 1'b1;
      for (int i = 0; i < 3; i++) step();
      n_chk++;
      if ({ch_active[0], ce[0]} !== 2'b11) begin
         n_fail++;
         $display("FAIL cancel_last act_ce got %b want 11",
                  {ch_active[0], ce[0]});
      end
      step();
      n_chk++;
      if ({ch_active[0], ce[0], divclk[0]} !== 3'b101) begin
         n_fail++;
         $display("FAIL cancel_nogap act_ce_dv got %b want 101",
                  {ch_active[0], ce[0], divclk[0]});
      end
   endtask

   task automatic test_inv();
      logic exp_t [6];
      exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      load0(8'd3);
      for (int i = 0; i < 5; i++) step();
      n_chk++;
      if (divclk[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL n4_start_dv got %b want 1", divclk[0]);
      end
      step();
      inv[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         n_chk++;
         if (divclk[0] !== exp_t[i]) begin
            n_fail++;
            $display("FAIL inv_cyc%0d dv got %b want %b",
                     i, divclk[0], exp_t[i]);
         end
      end
   endtask

   task automatic test_scan();
      scan_mode = 1'b1;
      step();
      n_chk++;
      if ({ce, divclk} !== 4'b1100) begin
         n_fail++;
         $display("FAIL scan_on ce_dv got %b want 1100", {ce, divclk});
      end
      step();
      step();
      n_chk++;
      if ({ce, divclk} !== 4'b1100) begin
         n_fail++;
         $display("FAIL scan_hold ce_dv got %b want 1100", {ce, divclk});
      end
      scan_mode = 1'b0;
      step();
      n_chk++;
      if ({ce[0], divclk[0]} !== 2'b00) begin
         n_fail++;
         $display("FAIL scan_exit ce_dv got %b want 00",
                  {ce[0], divclk[0]});
      end
      step();
      step();
      n_chk++;
      if ({ce[0], divclk[0]} !== 2'b01) begin
         n_fail++;
         $display("FAIL scan_resume2 ce_dv got %b want 01",
                  {ce[0], divclk[0]});
      end
      step();
      n_chk++;
      if ({ce[0], divclk[0]} !== 2'b11) begin
         n_fail++;
         $display("FAIL scan_resume3 ce_dv got %b want 11",
                  {ce[0], divclk[0]});
      end
   endtask

`ifdef CLKSRC_PHASE_SYNC_EN
   task automatic test_sync();
      logic [1:0] exp_ce;
      inv = '0;
      div_val = {8'd4, 8'd2};
      div_ld = 2'b11;
      ch_en = 2'b11;
      step();
      div_ld = '0;
      for (int i = 0; i < 8; i++) step();
      sync_pulse = 1'b1;
      step();
      sync_pulse = 1'b0;
      for (int j = 1; j <= 30; j++) begin
         exp_ce = {(j % 5) == 0, (j % 3) == 0};
         n_chk++;
         if (ce !== exp_ce) begin
            n_fail++;
            $display("FAIL sync_cyc%0d ce got %b want %b", j, ce, exp_ce);
         end
         step();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_ratio1();
      test_update();
      test_disable();
      test_inv();
      test_scan();
`ifdef CLKSRC_PHASE_SYNC_EN
      test_sync();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
